// File: rtl/fetch_unit.sv
// Instruction-fetch front end: owns the PC, issues credit-limited requests to a
// variable-latency instruction memory and queues in-order responses for decode.
module fetch_unit #(
   parameter int unsigned       ADDR_W   = 64,
   parameter int unsigned       DEPTH    = 4,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic              clk,
   input  logic              reset,
   output logic              imem_req,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic              imem_gnt,
   input  logic              imem_rvalid,
   input  logic [31:0]       imem_rdata,
   input  logic              redirect,
   input  logic              redirect_uncond,
   input  logic [ADDR_W-1:0] redirect_pc,
   input  logic [31:0]       redirect_instr,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [ADDR_W-1:0] out_pc,
   output logic [31:0]       out_instr
);

   localparam int unsigned PtrW = $clog2(DEPTH);
   localparam int unsigned CntW = PtrW + 1;
   localparam logic [CntW:0] DepthC = (CntW + 1)'(DEPTH);

   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [ADDR_W-1:0] q_pc_q    [DEPTH];
   logic [31:0]       q_instr_q [DEPTH];
   logic [PtrW-1:0]   q_rd_q, q_rd_d, q_wr_q, q_wr_d;
   logic [CntW-1:0]   q_cnt_q, q_cnt_d;
   logic [ADDR_W-1:0] p_pc_q    [DEPTH];
   logic [PtrW-1:0]   p_rd_q, p_rd_d, p_wr_q, p_wr_d;
   logic [CntW-1:0]   out_cnt_q, out_cnt_d;
   logic [CntW-1:0]   drop_q, drop_d;

   logic              grant, keep, pop;
   logic [ADDR_W-1:0] offset, target;
   logic              unused_instr;

   assign unused_instr = ^{redirect_instr[31:26]};

   // Queue slots plus in-flight requests never exceed DEPTH, so a response always has room.
   assign imem_req  = !reset && !redirect &&
                      (({1'b0, q_cnt_q} + {1'b0, out_cnt_q}) < DepthC);
   assign imem_addr = pc_q;
   assign grant     = imem_req && imem_gnt;
   assign keep      = imem_rvalid && !redirect && !reset && (drop_q == '0);

   assign out_valid = !reset && !redirect && (q_cnt_q != '0);
   assign out_pc    = q_pc_q[q_rd_q];
   assign out_instr = q_instr_q[q_rd_q];
   assign pop       = out_valid && out_ready;

   always_comb begin
      offset = redirect_uncond ? {{(ADDR_W-26){redirect_instr[25]}}, redirect_instr[25:0]}
                               : {{(ADDR_W-19){redirect_instr[23]}}, redirect_instr[23:5]};
      target = redirect_pc + (offset << 2);
   end

   always_comb begin
      pc_d      = pc_q;
      q_rd_d    = q_rd_q;
      q_wr_d    = q_wr_q;
      q_cnt_d   = q_cnt_q;
      p_rd_d    = p_rd_q;
      p_wr_d    = p_wr_q;
      drop_d    = drop_q;
      out_cnt_d = out_cnt_q + CntW'(grant) - CntW'(imem_rvalid);

      if (grant) p_wr_d = p_wr_q + PtrW'(1);
      if (imem_rvalid) p_rd_d = p_rd_q + PtrW'(1);

      if (redirect) begin
         pc_d    = target;
         q_rd_d  = '0;
         q_wr_d  = '0;
         q_cnt_d = '0;
         // Everything still in flight after this cycle belongs to the wrong path.
         drop_d  = out_cnt_q - CntW'(imem_rvalid);
      end else begin
         if (grant) pc_d = pc_q + ADDR_W'(4);
         if (keep) q_wr_d = q_wr_q + PtrW'(1);
         if (pop) q_rd_d = q_rd_q + PtrW'(1);
         q_cnt_d = q_cnt_q + CntW'(keep) - CntW'(pop);
         if (imem_rvalid && (drop_q != '0)) drop_d = drop_q - CntW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pc_q      <= RESET_PC;
         q_rd_q    <= '0;
         q_wr_q    <= '0;
         q_cnt_q   <= '0;
         p_rd_q    <= '0;
         p_wr_q    <= '0;
         out_cnt_q <= '0;
         drop_q    <= '0;
      end else begin
         pc_q      <= pc_d;
         q_rd_q    <= q_rd_d;
         q_wr_q    <= q_wr_d;
         q_cnt_q   <= q_cnt_d;
         p_rd_q    <= p_rd_d;
         p_wr_q    <= p_wr_d;
         out_cnt_q <= out_cnt_d;
         drop_q    <= drop_d;
      end
   end

   always_ff @(posedge clk) begin
      if (grant) p_pc_q[p_wr_q] <= pc_q;
      if (keep) begin
         q_pc_q[q_wr_q]    <= p_pc_q[p_rd_q];
         q_instr_q[q_wr_q] <= imem_rdata;
      end
   end

   resp_needs_request : assert property (@(posedge clk) disable iff (reset)
      imem_rvalid |-> (out_cnt_q != '0))
      else $error("fetch_unit: response with no outstanding request");

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized bench for fetch_unit: a memory model answers grants in order and a
// scoreboard checks that decode sees the architectural PC stream and memory contents.
module tb_fetch_unit;

   typedef struct {
      logic [63:0] addr;
      int          due;
   } req_t;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        imem_req;
   logic [63:0] imem_addr;
   logic        imem_gnt = 1'b0;
   logic        imem_rvalid = 1'b0;
   logic [31:0] imem_rdata = '0;
   logic        redirect = 1'b0;
   logic        redirect_uncond = 1'b0;
   logic [63:0] redirect_pc = '0;
   logic [31:0] redirect_instr = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [63:0] out_pc;
   logic [31:0] out_instr;

   int tot = 0;
   int bad = 0;
   int cnt = 0;
   int hs = 0;
   int gnt_pct = 100, rv_pct = 100, lat_min = 1, lat_max = 1;
   bit granted;
   req_t memq[$];
   logic [63:0] expq[$];
   logic [63:0] mpc = '0;

   fetch_unit #(.ADDR_W(64), .DEPTH(4), .RESET_PC(64'h0)) dut (
      .clk             (clk),
      .reset           (reset),
      .imem_req        (imem_req),
      .imem_addr       (imem_addr),
      .imem_gnt        (imem_gnt),
      .imem_rvalid     (imem_rvalid),
      .imem_rdata      (imem_rdata),
      .redirect        (redirect),
      .redirect_uncond (redirect_uncond),
      .redirect_pc     (redirect_pc),
      .redirect_instr  (redirect_instr),
      .out_valid       (out_valid),
      .out_ready       (out_ready),
      .out_pc          (out_pc),
      .out_instr       (out_instr)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [63:0] a);
      return (a[31:0] * 32'h9E3779B1) ^ a[63:32] ^ 32'h5A5A0F0F;
   endfunction

   function automatic logic [63:0] br_target(input logic [63:0] pc, input logic [31:0] ins,
                                             input bit unc);
      logic signed [25:0] b;
      logic signed [18:0] c;
      longint off;
      b = ins[25:0];
      c = ins[23:5];
      off = unc ? longint'(b) : longint'(c);
      return pc + 64'(off * 4);
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
      tot++;
      if (act !== want) begin
         bad++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, want, cnt);
      end
   endtask

   // One clock cycle of stimulus; returns with DUT outputs settled (1 time unit after negedge).
   task automatic cyc(input bit rst, input bit rdr, input bit unc, input logic [63:0] rpc,
                      input logic [31:0] rin, input bit rdy);
      @(negedge clk);
      cnt++;
      reset = rst;
      redirect = rdr;
      redirect_uncond = unc;
      redirect_pc = rpc;
      redirect_instr = rin;
      out_ready = rdy;
      if (rst) begin
         memq.delete();
         expq.delete();
         mpc = 64'h0;
      end
      if (rdr) begin
         expq.delete();
         mpc = br_target(rpc, rin, unc);
      end
      imem_rvalid = 1'b0;
      imem_rdata = $urandom;
      if (!rst && memq.size() > 0 && memq[0].due <= cnt && $urandom_range(99) < rv_pct) begin
         imem_rvalid = 1'b1;
         imem_rdata = mem_word(memq[0].addr);
         void'(memq.pop_front());
      end
      imem_gnt = ($urandom_range(99) < gnt_pct);
      while (expq.size() < 16) begin
         expq.push_back(mpc);
         mpc = mpc + 64'd4;
      end
      #1;
      granted = imem_req && imem_gnt;
      if (granted) memq.push_back('{imem_addr, cnt + int'($urandom_range(lat_max, lat_min))});
   endtask

   task automatic idle(input int n, input bit rdy);
      for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 64'h0, 32'h0, rdy);
   endtask

   // Scoreboard monitor: every accepted head must be the next architectural instruction.
   logic        prev_stall = 1'b0;
   logic [63:0] prev_pc = '0;
   always @(negedge clk) begin
      logic [63:0] e;
      #2;
      if (prev_stall && !redirect && !reset) begin
         chk("hold_valid", {63'h0, out_valid}, 64'h1);
         chk("hold_pc", out_pc, prev_pc);
      end
      prev_stall = out_valid && !out_ready;
      prev_pc = out_pc;
      if (out_valid && out_ready) begin
         hs++;
         if (expq.size() == 0) begin
            tot++;
            bad++;
            $display("FAIL scoreboard_empty: got pc %h expected no output", out_pc);
         end else begin
            e = expq.pop_front();
            chk("out_pc", out_pc, e);
            chk("out_instr", {32'h0, out_instr}, {32'h0, mem_word(e)});
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1);
   end

   initial begin
      int grants;
      bit found;
      logic [63:0] tgt;

      // Reset and zero-wait streaming.
      cyc(1'b1, 1'b0, 1'b0, 64'h0, 32'h0, 1'b1);
      cyc(1'b1, 1'b0, 1'b0, 64'h0, 32'h0, 1'b1);
      chk("rst_req", {63'h0, imem_req}, 64'h0);
      chk("rst_valid", {63'h0, out_valid}, 64'h0);
      idle(1, 1'b1);
      chk("post_rst_req", {63'h0, imem_req}, 64'h1);
      chk("post_rst_addr", imem_addr, 64'h0);
      chk("post_rst_valid0", {63'h0, out_valid}, 64'h0);
      idle(1, 1'b1);
      chk("post_rst_valid1", {63'h0, out_valid}, 64'h0);
      for (int i = 0; i < 16; i++) begin
         idle(1, 1'b1);
         chk("stream_valid", {63'h0, out_valid}, 64'h1);
      end

      // Backpressure: credit limits grants to DEPTH.
      cyc(1'b1, 1'b0, 1'b0, 64'h0, 32'h0, 1'b0);
      grants = 0;
      for (int i = 0; i < 20; i++) begin
         idle(1, 1'b0);
         if (granted) grants++;
         if (out_valid) chk("stall_pc", out_pc, 64'h0);
      end
      chk("stall_grants", 64'(grants), 64'd4);
      chk("stall_req", {63'h0, imem_req}, 64'h0);
      idle(30, 1'b1);

      // CB-format redirect, negative offset.
      cyc(1'b0, 1'b1, 1'b0, 64'h100, {8'h0, 19'h7FFFF, 5'h0}, 1'b1);
      chk("redir_req", {63'h0, imem_req}, 64'h0);
      chk("redir_valid", {63'h0, out_valid}, 64'h0);
      idle(1, 1'b1);
      chk("cb_addr", imem_addr, 64'hFC);
      idle(10, 1'b1);

      // B-format redirects, including wrap below zero.
      cyc(1'b0, 1'b1, 1'b1, 64'h40, 32'h0000_0010, 1'b1);
      idle(1, 1'b1);
      chk("b_addr", imem_addr, 64'h80);
      idle(10, 1'b1);
      cyc(1'b0, 1'b1, 1'b1, 64'h0, 32'h03FF_FFFF, 1'b1);
      idle(1, 1'b1);
      chk("b_wrap_addr", imem_addr, 64'hFFFF_FFFF_FFFF_FFFC);
      idle(10, 1'b1);

      // 3-cycle memory, redirect with 3 outstanding and one returning that cycle.
      lat_min = 3;
      lat_max = 3;
      found = 1'b0;
      for (int i = 0; i < 50 && !found; i++) begin
         if (memq.size() == 3 && memq[0].due <= cnt + 1) found = 1'b1;
         else idle(1, 1'b1);
      end
      chk("lat3_setup", {63'h0, found}, 64'h1);
      cyc(1'b0, 1'b1, 1'b1, 64'h200, 32'h0000_0008, 1'b1);
      found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         idle(1, 1'b1);
         if (out_valid) found = 1'b1;
      end
      chk("lat3_first_valid", {63'h0, found}, 64'h1);
      chk("lat3_first_pc", out_pc, 64'h220);
      idle(10, 1'b1);

      // Reset mid-operation with queued and in-flight entries.
      lat_min = 5;
      lat_max = 5;
      cyc(1'b1, 1'b0, 1'b0, 64'h0, 32'h0, 1'b0);
      idle(7, 1'b0);
      cyc(1'b1, 1'b0, 1'b0, 64'h0, 32'h0, 1'b0);
      chk("midrst_req", {63'h0, imem_req}, 64'h0);
      chk("midrst_valid", {63'h0, out_valid}, 64'h0);
      lat_min = 1;
      lat_max = 1;
      idle(1, 1'b1);
      chk("midrst_restart_valid", {63'h0, out_valid}, 64'h0);
      chk("midrst_restart_addr", imem_addr, 64'h0);
      idle(20, 1'b1);

      // Randomized traffic with redirects and occasional resets.
      gnt_pct = 70;
      rv_pct = 80;
      lat_min = 1;
      lat_max = 4;
      for (int i = 0; i < 2000; i++) begin
         if ($urandom_range(999) < 5) begin
            cyc(1'b1, 1'b0, 1'b0, 64'h0, 32'h0, 1'b1);
         end else if ($urandom_range(99) < 3) begin
            tgt = {$urandom, $urandom};
            cyc(1'b0, 1'b1, 1'($urandom_range(1)), tgt, $urandom, 1'($urandom_range(99) < 70));
         end else begin
            cyc(1'b0, 1'b0, 1'b0, 64'h0, 32'h0, 1'($urandom_range(99) < 70));
         end
      end
      idle(20, 1'b1);
      chk("progress", {63'h0, hs > 500}, 64'h1);

      $display("test done: total=%0d bad=%0d", tot, bad);
      $finish;
   end

endmodule
